// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto one
// single-port memory. At most one transaction is outstanding at a time.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   if_req/if_addr        fetch request and word address (address sampled on grant)
//   if_gnt                fetch accepted (combinational, valid in the IDLE cycle)
//   if_rvalid/if_rdata    fetch completion pulse and held instruction word
//   d_req/d_addr/d_wdata/d_byteen
//                         data request; byteen != 0 is a store, 0 is a load
//   d_gnt                 data accepted (combinational, valid in the IDLE cycle)
//   d_rvalid/d_rdata      data completion pulse and held load data (0 for stores)
//   err                   pulses with the rvalid of a timed-out transaction
//   mem_req/mem_addr/mem_wdata/mem_byteen
//                         registered memory request, held until mem_ready
//   mem_rdata/mem_ready   memory response, only looked at while busy
//
// Parameters
//   STARVE_LIMIT  data grants allowed in a row while a fetch waits
//   TIMEOUT       busy cycles without mem_ready before abort (must be >= 1)
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_D  = 2'd2
  } state_t;

  // Widths sized so the counters can hold their limit even for tiny parameters.
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // The counter starts at 0 on entry, so the TIMEOUT-th idle-waiting busy
  // cycle is the one where it holds TIMEOUT-1; that cycle triggers the abort.
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  function automatic logic [SW-1:0] f_starve_inc(input logic [SW-1:0] cnt);
    return (cnt == STARVE_MAX) ? cnt : cnt + SW'(1);
  endfunction

  state_t      r_state;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_tmo;
  logic        r_if_rvalid;
  logic        r_d_rvalid;
  logic        r_err;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_byteen;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic        w_idle;
  logic        w_fetch_win;
  logic        w_if_take;
  logic        w_d_take;
  logic        w_done;
  logic        w_abort;
  logic [31:0] w_rsp_data;

  always_comb begin
    w_idle      = (r_state == S_IDLE);
    // Data normally wins; a waiting fetch wins once data has had its quota.
    w_fetch_win = if_req && (!d_req || (r_starve == STARVE_MAX));
    w_if_take   = w_idle && w_fetch_win;
    w_d_take    = w_idle && d_req && !w_fetch_win;
    w_done      = !w_idle && mem_ready;
    w_abort     = !w_idle && !mem_ready && (r_tmo == TMO_LAST);
    // Stores and aborts return zero data.
    w_rsp_data  = (w_done && (r_mem_byteen == 4'b0000)) ? mem_rdata : 32'h0;
  end

  // Grants are decided in the IDLE cycle itself; gating with reset keeps them
  // low while reset is held even though the state already reads IDLE.
  assign if_gnt = w_if_take & reset;
  assign d_gnt  = w_d_take & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_starve     <= '0;
      r_tmo        <= '0;
      r_if_rvalid  <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_err        <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_byteen <= 4'h0;
      r_if_rdata   <= 32'h0;
      r_d_rdata    <= 32'h0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_if_take) begin
            r_state      <= S_BUSY_IF;
            r_mem_req    <= 1'b1;
            r_mem_addr   <= if_addr;
            r_mem_wdata  <= 32'h0;
            r_mem_byteen <= 4'h0;
            r_tmo        <= '0;
            r_starve     <= '0;
          end else if (w_d_take) begin
            r_state      <= S_BUSY_D;
            r_mem_req    <= 1'b1;
            r_mem_addr   <= d_addr;
            r_mem_wdata  <= d_wdata;
            r_mem_byteen <= d_byteen;
            r_tmo        <= '0;
            // Only a grant that actually made a fetch wait counts toward starvation.
            r_starve     <= if_req ? f_starve_inc(r_starve) : '0;
          end
        end
        S_BUSY_IF, S_BUSY_D: begin
          if (w_done || w_abort) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            r_err     <= w_abort;
            if (r_state == S_BUSY_IF) begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= w_rsp_data;
            end else begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= w_rsp_data;
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign if_rvalid  = r_if_rvalid;
  assign if_rdata   = r_if_rdata;
  assign d_rvalid   = r_d_rvalid;
  assign d_rdata    = r_d_rdata;
  assign err        = r_err;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_byteen = r_mem_byteen;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;

  localparam int SL = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_byteen   (d_byteen),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .err        (err),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the memory, what was captured, how long it has waited.
  int          m_owner;      // 0 none, 1 fetch, 2 data
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_wait;
  int          m_starve;
  logic        m_if_rv, m_d_rv, m_err;
  logic [31:0] m_if_rdata, m_d_rdata;

  // Inputs and expected grants as seen just before the coming edge.
  logic        s_if_gnt, s_d_gnt, s_if_req, s_ready;
  logic [31:0] s_if_addr, s_d_addr, s_d_wdata, s_rdata;
  logic [3:0]  s_d_be;
  logic        e_if_gnt, e_d_gnt;

  int stall_left = 0;

  task automatic model_reset();
    m_owner = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_wait = 0; m_starve = 0;
    m_if_rv = 0; m_d_rv = 0; m_err = 0; m_if_rdata = 0; m_d_rdata = 0;
    s_if_gnt = 0; s_d_gnt = 0;
  endtask

  task automatic model_finish(input logic [31:0] v, input logic e);
    if (m_owner == 1) begin m_if_rv = 1; m_if_rdata = v; end
    else begin m_d_rv = 1; m_d_rdata = v; end
    m_err   = e;
    m_owner = 0;
  endtask

  task automatic model_edge();
    if (!reset) return;
    m_if_rv = 0; m_d_rv = 0; m_err = 0;
    if (m_owner == 0) begin
      if (s_if_gnt) begin
        m_owner = 1; m_addr = s_if_addr; m_wdata = 0; m_be = 0; m_wait = 0;
        m_starve = 0;
      end else if (s_d_gnt) begin
        m_owner = 2; m_addr = s_d_addr; m_wdata = s_d_wdata; m_be = s_d_be; m_wait = 0;
        m_starve = s_if_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
      end
    end else begin
      if (s_ready) model_finish((m_be != 0) ? 32'h0 : s_rdata, 1'b0);
      else begin
        m_wait++;
        if (m_wait == TO) model_finish(32'h0, 1'b1);
      end
    end
  endtask

  // Settle, compare every output against the model, remember pre-edge values.
  task automatic check_cycle();
    logic fw;
    #1;
    fw = if_req && (!d_req || m_starve == SL);
    e_if_gnt = reset && (m_owner == 0) && fw;
    e_d_gnt  = reset && (m_owner == 0) && d_req && !fw;
    chk("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
    chk("d_gnt",     32'(d_gnt),     32'(e_d_gnt));
    chk("mem_req",   32'(mem_req),   32'(m_owner != 0));
    chk("if_rvalid", 32'(if_rvalid), 32'(m_if_rv));
    chk("d_rvalid",  32'(d_rvalid),  32'(m_d_rv));
    chk("err",       32'(err),       32'(m_err));
    chk("if_rdata",  if_rdata,       m_if_rdata);
    chk("d_rdata",   d_rdata,        m_d_rdata);
    if (m_owner != 0) begin
      chk("mem_addr",   mem_addr,          m_addr);
      chk("mem_wdata",  mem_wdata,         m_wdata);
      chk("mem_byteen", 32'(mem_byteen),   32'(m_be));
    end
    if (!reset) begin
      chk("rst_mem_addr",   mem_addr,        32'h0);
      chk("rst_mem_wdata",  mem_wdata,       32'h0);
      chk("rst_mem_byteen", 32'(mem_byteen), 32'h0);
    end
    s_if_gnt = e_if_gnt; s_d_gnt = e_d_gnt; s_if_req = if_req; s_ready = mem_ready;
    s_if_addr = if_addr; s_d_addr = d_addr; s_d_wdata = d_wdata; s_d_be = d_byteen;
    s_rdata = mem_rdata;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet_inputs();
    if_req = 0; d_req = 0; mem_ready = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    d_byteen = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset = 0;
    model_reset();
    check_cycle(); advance();
    check_cycle(); advance();
    reset = 1;
  endtask

  task automatic rand_drive();
    if (if_req && s_if_gnt) if_req = 0;
    else if (if_req && $urandom_range(0, 99) < 2) if_req = 0;
    if (!if_req && $urandom_range(0, 99) < 35) begin if_req = 1; if_addr = $urandom; end
    if (d_req && s_d_gnt) d_req = 0;
    else if (d_req && $urandom_range(0, 99) < 2) d_req = 0;
    if (!d_req && $urandom_range(0, 99) < 45) begin
      d_req = 1; d_addr = $urandom; d_wdata = $urandom;
      d_byteen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    end
    if (stall_left > 0) begin
      mem_ready = 0; stall_left--;
    end else begin
      mem_ready = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 2) stall_left = 10;
    end
    mem_rdata = $urandom;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    int k;
    quiet_inputs();
    reset = 0;
    model_reset();
    check_cycle();
    chk("reset_mem_req", 32'(mem_req), 32'h0);
    advance();
    do_reset();

    // Single fetch: gnt in N, address in N+1, data in N+2.
    if_req = 1; if_addr = 32'h3000; mem_rdata = 32'h24010005;
    check_cycle(); chk("fetch_gnt", 32'(if_gnt), 32'h1); advance();
    if_req = 0; mem_ready = 1;
    check_cycle(); chk("fetch_addr", mem_addr, 32'h3000); advance();
    mem_ready = 0;
    check_cycle();
    chk("fetch_rvalid", 32'(if_rvalid), 32'h1);
    chk("fetch_rdata", if_rdata, 32'h24010005);
    advance();

    // Simultaneous requests: data first, fetch in the d_rvalid cycle.
    if_req = 1; if_addr = 32'h100; d_req = 1; d_addr = 32'h10; d_byteen = 0;
    mem_rdata = 32'h5555AAAA;
    check_cycle();
    chk("sim_dgnt", 32'(d_gnt), 32'h1);
    chk("sim_ifgnt_wait", 32'(if_gnt), 32'h0);
    advance();
    d_req = 0; mem_ready = 1;
    check_cycle(); advance();
    mem_ready = 0;
    check_cycle();
    chk("sim_drvalid", 32'(d_rvalid), 32'h1);
    chk("sim_ifgnt", 32'(if_gnt), 32'h1);
    advance();
    if_req = 0; mem_ready = 1;
    check_cycle(); advance();
    mem_ready = 0;
    check_cycle(); chk("sim_ifrvalid", 32'(if_rvalid), 32'h1); advance();

    // Starvation: both held high, memory always ready.
    do_reset();
    if_req = 1; d_req = 1; mem_ready = 1; d_byteen = 0; mem_rdata = 32'h1;
    for (int i = 0; i < 30; i++) begin
      check_cycle();
      if (d_gnt) seq.push_back(0);
      if (if_gnt) seq.push_back(1);
      advance();
    end
    chk("starve_len", 32'(seq.size() >= 10), 32'h1);
    for (int i = 0; i < 10 && i < seq.size(); i++)
      chk("starve_seq", 32'(seq[i]), 32'((i % 5) == 4));
    quiet_inputs();
    for (int i = 0; i < 3; i++) begin check_cycle(); advance(); end

    // Store: registered write fields held through a stall, zero read data.
    d_req = 1; d_addr = 32'h24; d_wdata = 32'hABCD1234; d_byteen = 4'b0011;
    mem_rdata = 32'hFFFFFFFF;
    check_cycle(); chk("st_gnt", 32'(d_gnt), 32'h1); advance();
    d_req = 0;
    for (int i = 0; i < 2; i++) begin
      check_cycle();
      chk("st_byteen", 32'(mem_byteen), 32'h3);
      chk("st_wdata", mem_wdata, 32'hABCD1234);
      chk("st_addr", mem_addr, 32'h24);
      advance();
    end
    mem_ready = 1;
    check_cycle(); advance();
    mem_ready = 0;
    check_cycle();
    chk("st_rvalid", 32'(d_rvalid), 32'h1);
    chk("st_rdata", d_rdata, 32'h0);
    advance();

    // Timeout: no mem_ready, abort arrives 9 cycles after the grant.
    d_req = 1; d_addr = 32'h40; d_byteen = 0;
    check_cycle(); chk("to_gnt", 32'(d_gnt), 32'h1); advance();
    d_req = 0;
    k = 1;
    while (k <= 20) begin
      check_cycle();
      if (d_rvalid) break;
      advance();
      k++;
    end
    chk("to_latency", 32'(k), 32'd9);
    chk("to_err", 32'(err), 32'h1);
    chk("to_rdata", d_rdata, 32'h0);
    advance();
    check_cycle(); chk("to_idle", 32'(mem_req), 32'h0); advance();

    // Reset during a data transaction, pending fetch granted at release.
    d_req = 1; d_addr = 32'h80; d_byteen = 0;
    check_cycle(); advance();
    d_req = 0;
    check_cycle(); advance();
    reset = 0; if_req = 1; if_addr = 32'h200;
    model_reset();
    check_cycle(); chk("rst_memreq", 32'(mem_req), 32'h0); advance();
    check_cycle(); advance();
    reset = 1;
    check_cycle();
    chk("rst_ifgnt", 32'(if_gnt), 32'h1);
    chk("rst_no_drvalid", 32'(d_rvalid), 32'h0);
    advance();
    if_req = 0;
    for (int i = 0; i < 4; i++) begin check_cycle(); advance(); end

    // Randomized traffic with one reset in the middle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      if (i == 1500) begin reset = 0; model_reset(); end
      if (i == 1503) reset = 1;
      check_cycle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch request waits.
REQ-002 Parameter TIMEOUT, default 255: maximum BUSY cycles without mem_ready before abort.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-005 if_req  in  1  fetch request; held high until if_gnt.
REQ-006 if_addr  in  32  fetch word address; sampled on grant.
REQ-007 if_gnt  out  1  one-cycle pulse: fetch request accepted.
REQ-008 if_rvalid  out  1  one-cycle pulse: if_rdata valid.
REQ-009 if_rdata  out  32  fetched instruction word.
REQ-010 d_req  in  1  data request; held high until d_gnt.
REQ-011 d_addr  in  32  data address; sampled on grant.
REQ-012 d_wdata  in  32  store data; sampled on grant.
REQ-013 d_byteen  in  4  byte enables; nonzero = store, zero = load.
REQ-014 d_gnt  out  1  one-cycle pulse: data request accepted.
REQ-015 d_rvalid  out  1  one-cycle pulse: load data valid or store acknowledged.
REQ-016 d_rdata  out  32  load data; 0 for stores.
REQ-017 err  out  1  one-cycle pulse with the rvalid of an aborted transaction.
REQ-018 mem_req  out  1  request to single-port memory, held until mem_ready.
REQ-019 mem_addr, mem_wdata  out  32 each  registered address and store data.
REQ-020 mem_byteen  out  4  registered byte enables.
REQ-021 mem_rdata  in  32  memory read data, valid with mem_ready.
REQ-022 mem_ready  in  1  memory completion, sampled only while mem_req is high.

Function
REQ-023 States IDLE, BUSY_IF, BUSY_D; at most one transaction outstanding.
REQ-024 IDLE arbitration:
- d_req wins over if_req, unless starve_cnt == STARVE_LIMIT and if_req is high; then the fetch wins.
- On a grant, assert the owner's gnt that cycle, capture addr/wdata/byteen (fetch: byteen 0), and enter BUSY_IF or BUSY_D.
REQ-025 starve_cnt: increment, saturating at STARVE_LIMIT, on a data grant while if_req is high; clear on any fetch grant, or on a data grant while if_req is low.
REQ-026 mem_req SHALL be high in every BUSY cycle and low in IDLE; mem_addr/mem_wdata/mem_byteen stay stable while mem_req is high.
REQ-027 On the first BUSY cycle with mem_ready high:
- register mem_rdata (or 0 for a store) into the owner's rdata;
- pulse the owner's rvalid on the next cycle;
- return to IDLE on that next cycle.
REQ-028 Minimum request-to-rvalid latency SHALL be 2 cycles: gnt in cycle N, mem_ready in N+1, rvalid in N+2; the next grant is possible in N+2.
REQ-029 BUSY timeout counter: clear on entry; if it reaches TIMEOUT without mem_ready, pulse the owner's rvalid and err with rdata 0 on the next cycle and return to IDLE.
REQ-030 if_rdata/d_rdata SHALL hold their last values between rvalid pulses.
REQ-031 A request deasserted before its grant SHALL be dropped with no gnt and no memory access.
REQ-032 mem_ready while in IDLE SHALL be ignored.
REQ-033 Simultaneous if_req/d_req in the cycle the previous transaction completes: arbitration occurs in the following IDLE cycle.

Reset
REQ-034 While reset is low, all outputs SHALL be 0: gnts, rvalids, err, mem_req, mem_addr, mem_wdata, mem_byteen, if_rdata, d_rdata.
REQ-035 While reset is low: state = IDLE, starve_cnt = 0, timeout counter = 0.
REQ-036 Reset mid-transaction SHALL abort it with no rvalid after release; the first grant is possible in the first clk edge after release.

Verification
REQ-037 Fetch only: if_req=1, if_addr=0x3000, mem_ready high one cycle after gnt, mem_rdata=0x24010005 -> if_gnt in cycle N, mem_addr=0x3000 in N+1, if_rvalid with if_rdata=0x24010005 in N+2.
REQ-038 Simultaneous: if_req and d_req both high, d_addr=0x10, d_byteen=0 -> d_gnt first; if_gnt on the first IDLE cycle after d_rvalid.
REQ-039 Starvation: d_req and if_req held high continuously with STARVE_LIMIT=4 -> exactly 4 d_gnts, then one if_gnt, then data resumes.
REQ-040 Store: d_byteen=4'b0011, d_wdata=0xABCD1234, d_addr=0x24 -> mem_byteen=0011, mem_wdata=0xABCD1234 while mem_req is high; d_rvalid with d_rdata=0.
REQ-041 Timeout: TIMEOUT=8, mem_ready held low -> d_rvalid and err pulse together 9 cycles after d_gnt; state returns to IDLE.
REQ-042 Reset low during BUSY_D -> mem_req=0 immediately; no d_rvalid after release; a pending if_req is granted on the first edge after release.
